// File: rtl/hub75_pkg.sv
// Shared constants, pixel types and drain-state encoding for the HUB75 receiver.
package hub75_pkg;

   localparam int COLS     = 32;
   localparam int ROW_BITS = 3;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_UPPER = 2'd1,
      ST_LOWER = 2'd2
   } drain_t;

   // A stored pixel is {rgb1, rgb2}; pick the half that belongs to the row being drained.
   function automatic rgb_t pix_sel(input logic [5:0] pix, input logic lower);
      rgb_t v;
      if (lower) begin
         v = pix[2:0];
      end else begin
         v = pix[5:3];
      end
      return v;
   endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// Two-flop synchronizer for one HUB75 control line with rising-edge detect.
module hub75_rx_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   // Metastability chain plus one extra stage to compare against for edges.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= i_d;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_q    = r_s2;
   assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: captures shifted lines, then drains them as upper/lower pixel writes.
module hub75_rx
   import hub75_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sclk,
   input  logic                i_lat,
   input  logic                i_oe_n,
   input  logic [ROW_BITS-1:0] i_a,
   input  logic [2:0]          i_rgb1,
   input  logic [2:0]          i_rgb2,
   output logic                o_wr_valid,
   input  logic                i_wr_ready,
   output logic [ROW_BITS:0]   o_wr_row,
   output logic [4:0]          o_wr_col,
   output logic [2:0]          o_wr_rgb,
   output logic [ROW_BITS-1:0] o_disp_row,
   output logic                o_lit,
   output logic                o_frame_done,
   output logic                o_overrun,
   output logic                o_len_err
);

   logic w_sclk_rise, w_lat_rise, w_oe_rise_unused;
   logic w_sclk_s, w_lat_s, w_oe_n_s, w_unused_lvl;
   logic [ROW_BITS+5:0] r_dat1, r_dat2;
   logic [ROW_BITS-1:0] w_a_s;
   logic [5:0] w_pix_s;
   logic [COLS-1:0][5:0] r_shift, r_line, w_shift_nxt, w_line_nxt;
   logic [5:0] r_cnt, w_cnt_nxt, w_shamt;
   logic [7:0] w_bitsh;
   logic [4:0] w_col_inc;
   logic w_accept;
   drain_t r_state;
   logic r_valid, r_lit, r_frame, r_ovr, r_len;
   logic [ROW_BITS:0] r_row;
   logic [4:0] r_col;
   logic [2:0] r_rgb;
   logic [ROW_BITS-1:0] r_disp;

   hub75_rx_sync u_sync_sclk (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_q(w_sclk_s), .o_rise(w_sclk_rise));
   hub75_rx_sync u_sync_lat  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_lat),  .o_q(w_lat_s),  .o_rise(w_lat_rise));
   hub75_rx_sync u_sync_oe   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_oe_n), .o_q(w_oe_n_s), .o_rise(w_oe_rise_unused));

   assign w_unused_lvl = w_sclk_s ^ w_lat_s;
   assign w_a_s        = r_dat2[ROW_BITS+5:6];
   assign w_pix_s      = r_dat2[5:0];
   assign w_accept     = w_lat_rise && (r_state == ST_IDLE);
   assign w_col_inc    = r_col + 5'd1;

   // Shift before a coincident latch; a short line is left-aligned so the first bit lands in column 31.
   always_comb begin
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      if (w_sclk_rise) begin
         w_shift_nxt = {r_shift[COLS-2:0], w_pix_s};
         w_cnt_nxt   = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;
      end else begin
         w_shift_nxt = r_shift;
         w_cnt_nxt   = r_cnt;
      end
      if (w_cnt_nxt >= 6'd32) begin
         w_shamt = 6'd0;
      end else begin
         w_shamt = 6'd32 - w_cnt_nxt;
      end
      w_bitsh    = {2'b00, w_shamt} * 8'd6;
      w_line_nxt = w_shift_nxt << w_bitsh;
   end

   // Pixel storage carries no reset: stale data is masked by the shift count.
   always_ff @(posedge i_clk) begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
         r_line <= w_line_nxt;
      end
   end

   // Data synchronizers, latch handling, sticky flags and the drain FSM with registered write port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dat1  <= '0;
         r_dat2  <= '0;
         r_cnt   <= 6'd0;
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_row   <= '0;
         r_col   <= 5'd0;
         r_rgb   <= 3'd0;
         r_disp  <= 3'd7;
         r_lit   <= 1'b0;
         r_frame <= 1'b0;
         r_ovr   <= 1'b0;
         r_len   <= 1'b0;
      end else begin
         r_dat1  <= {i_a, i_rgb1, i_rgb2};
         r_dat2  <= r_dat1;
         r_lit   <= ~w_oe_n_s;
         r_frame <= 1'b0;
         r_cnt   <= w_lat_rise ? 6'd0 : w_cnt_nxt;
         if (w_lat_rise && (r_state != ST_IDLE)) begin
            r_ovr <= 1'b1;
         end
         if (w_accept) begin
            r_disp  <= w_a_s;
            r_frame <= (w_a_s == 3'd0) && (r_disp == 3'd7);
            r_len   <= r_len | (w_cnt_nxt != 6'd32);
            r_state <= ST_UPPER;
            r_valid <= 1'b1;
            r_col   <= 5'd0;
            r_row   <= {1'b0, w_a_s};
            r_rgb   <= pix_sel(w_line_nxt[0], 1'b0);
         end else if (r_valid && i_wr_ready) begin
            case (r_state)
               ST_UPPER: begin
                  if (r_col == 5'd31) begin
                     r_state <= ST_LOWER;
                     r_col   <= 5'd0;
                     r_row   <= {1'b1, r_disp};
                     r_rgb   <= pix_sel(r_line[0], 1'b1);
                  end else begin
                     r_col <= w_col_inc;
                     r_rgb <= pix_sel(r_line[w_col_inc], 1'b0);
                  end
               end
               ST_LOWER: begin
                  if (r_col == 5'd31) begin
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                  end else begin
                     r_col <= w_col_inc;
                     r_rgb <= pix_sel(r_line[w_col_inc], 1'b1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_wr_valid   = r_valid;
   assign o_wr_row     = r_row;
   assign o_wr_col     = r_col;
   assign o_wr_rgb     = r_rgb;
   assign o_disp_row   = r_disp;
   assign o_lit        = r_lit;
   assign o_frame_done = r_frame;
   assign o_overrun    = r_ovr;
   assign o_len_err    = r_len;

endmodule

// File: tb/tb_hub75_rx.sv
// Randomized scoreboard bench for hub75_rx against a list-based line model.
module tb_hub75_rx;

   logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, lat = 1'b0, oe_n = 1'b1, wr_ready = 1'b0;
   logic [2:0] a = 3'd0, rgb1 = 3'd0, rgb2 = 3'd0;
   logic wr_valid, frame_done, overrun, len_err, lit;
   logic [3:0] wr_row;
   logic [4:0] wr_col;
   logic [2:0] wr_rgb, disp_row;

   int checks = 0, errors = 0;
   int writes = 0, vcycles = 0, got_frames = 0, exp_frames = 0;
   int ready_mode = 1;
   logic [11:0] exp_q[$];
   logic [5:0] shifted[$];
   logic [2:0] m_disp = 3'd7;
   bit m_ovr = 1'b0, m_len = 1'b0;

   always #5 clk = ~clk;

   hub75_rx dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_lat(lat), .i_oe_n(oe_n),
      .i_a(a), .i_rgb1(rgb1), .i_rgb2(rgb2),
      .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_row(wr_row), .o_wr_col(wr_col),
      .o_wr_rgb(wr_rgb), .o_disp_row(disp_row), .o_lit(lit), .o_frame_done(frame_done),
      .o_overrun(overrun), .o_len_err(len_err)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Line model: k-th shifted pixel goes to column 31-k; beyond 32 shifts only the newest 32 count.
   function automatic void model_latch(input logic [2:0] av);
      int n, off, idx;
      logic [5:0] px;
      logic [2:0] c3;
      n   = shifted.size();
      off = (n > 32) ? n - 32 : 0;
      if (exp_q.size() != 0) begin
         m_ovr = 1'b1;
      end else begin
         if (n != 32) m_len = 1'b1;
         if (av == 3'd0 && m_disp == 3'd7) exp_frames++;
         for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < 32; c++) begin
               idx = off + 31 - c;
               px  = (idx < n) ? shifted[idx] : 6'd0;
               c3  = (h == 1) ? px[2:0] : px[5:3];
               exp_q.push_back({h[0], av, 5'(c), c3});
            end
         end
         m_disp = av;
      end
      shifted.delete();
   endfunction

   logic [11:0] prev_out;
   bit prev_stall = 1'b0, prev_frame = 1'b0;

   // Monitor: pops the scoreboard on each handshake and checks stall stability and frame pulses.
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_frame = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {wr_valid, wr_row, wr_col, wr_rgb}, {1'b1, prev_out});
         if (frame_done) begin
            got_frames++;
            check("frame_single", prev_frame, 0);
            check("frame_align", {wr_valid, wr_row, wr_col}, {1'b1, 4'd0, 5'd0});
         end
         prev_frame = frame_done;
         if (wr_valid) vcycles++;
         if (wr_valid && wr_ready) begin
            writes++;
            check("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("write_pix", {wr_row, wr_col, wr_rgb}, e);
            end
         end
         prev_stall = wr_valid && !wr_ready;
         prev_out   = {wr_row, wr_col, wr_rgb};
      end
   end

   // Sink ready pattern: 0 low, 1 high, 2 toggling, otherwise random.
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: wr_ready = 1'b0;
         1: wr_ready = 1'b1;
         2: wr_ready = ~wr_ready;
         default: wr_ready = 1'($urandom_range(0, 1));
      endcase
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic shift_px(input logic [2:0] p1, input logic [2:0] p2);
      rgb1 = p1; rgb2 = p2;
      cyc(2);
      shifted.push_back({p1, p2});
      sclk = 1'b1;
      cyc(2);
      sclk = 1'b0;
      cyc(1);
   endtask

   task automatic rand_shifts(input int n);
      for (int i = 0; i < n; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
   endtask

   task automatic do_latch(input logic [2:0] av);
      a = av;
      cyc(2);
      model_latch(av);
      lat = 1'b1;
      cyc(2);
      lat = 1'b0;
      cyc(2);
   endtask

   // Final shift edge and latch edge arrive together; the latched line must include that pixel.
   task automatic shift_latch(input logic [2:0] p1, input logic [2:0] p2, input logic [2:0] av);
      rgb1 = p1; rgb2 = p2; a = av;
      cyc(2);
      shifted.push_back({p1, p2});
      model_latch(av);
      sclk = 1'b1; lat = 1'b1;
      cyc(2);
      sclk = 1'b0; lat = 1'b0;
      cyc(2);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      check("drain_done", exp_q.size(), 0);
      exp_q.delete();
      cyc(3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(3);
      exp_q.delete(); shifted.delete();
      m_disp = 3'd7; m_ovr = 1'b0; m_len = 1'b0;
      rst_n = 1'b1;
      cyc(3);
   endtask

   initial begin
      int w0, f0, k, nsh;
      logic [2:0] c3;
      cyc(3);
      check("rst_valid", wr_valid, 0);
      check("rst_row", wr_row, 0);
      check("rst_col", wr_col, 0);
      check("rst_rgb", wr_rgb, 0);
      check("rst_disp", disp_row, 7);
      check("rst_lit", lit, 0);
      check("rst_frame", frame_done, 0);
      check("rst_flags", {overrun, len_err}, 0);
      rst_n = 1'b1;
      cyc(3);

      oe_n = 1'b0; cyc(5); check("lit_on", lit, 1);
      oe_n = 1'b1; cyc(5); check("lit_off", lit, 0);

      // Basic line: column c carries c on rgb1 and ~c on rgb2, first shift is column 31.
      ready_mode = 1;
      for (int c = 31; c >= 0; c--) begin
         c3 = 3'(c);
         shift_px(c3, ~c3);
      end
      w0 = writes; vcycles = 0;
      do_latch(3'd3);
      wait_drain(1000);
      check("basic_writes", writes - w0, 64);
      check("basic_drain_cycles", vcycles, 64);
      check("basic_disp", disp_row, 3);
      check("basic_flags", {overrun, len_err}, 0);

      // Frame sequence rows 0..7 then 0.
      for (int r = 0; r < 9; r++) begin
         if (r == 8) f0 = got_frames;
         rand_shifts(32);
         do_latch(3'(r % 8));
         wait_drain(1000);
      end
      check("frame_last_pulse", got_frames - f0, 1);
      check("frame_count", got_frames, exp_frames);

      // Ready toggling every cycle.
      ready_mode = 2;
      rand_shifts(32);
      w0 = writes;
      do_latch(3'($urandom_range(0, 7)));
      wait_drain(1000);
      check("toggle_writes", writes - w0, 64);

      // Overrun: second latch while the first line is stalled.
      do_reset();
      ready_mode = 0;
      rand_shifts(32);
      w0 = writes;
      do_latch(3'd5);
      cyc(4);
      rand_shifts(0);
      do_latch(3'd6);
      check("ovr_flag", overrun, 1);
      check("ovr_disp", disp_row, 5);
      ready_mode = 1;
      wait_drain(1000);
      cyc(20);
      check("ovr_writes", writes - w0, 64);

      // Short line: 30 shifts leave columns 0 and 1 empty.
      do_reset();
      rand_shifts(30);
      do_latch(3'd2);
      wait_drain(1000);
      check("len_flag", len_err, 1);
      check("len_ovr", overrun, 0);

      // Randomized lines with varied lengths, sink behaviour and coincident edges.
      do_reset();
      for (int l = 0; l < 6; l++) begin
         ready_mode = $urandom_range(1, 3);
         case ($urandom_range(0, 3))
            0: nsh = 70;
            1: nsh = $urandom_range(20, 40);
            default: nsh = 32;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            rand_shifts(nsh - 1);
            shift_latch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         end else begin
            rand_shifts(nsh);
            do_latch(3'($urandom_range(0, 7)));
         end
         wait_drain(2000);
      end
      check("rand_disp", disp_row, m_disp);
      check("rand_len", len_err, m_len);
      check("rand_ovr", overrun, m_ovr);

      // Reset in the middle of the upper half drain.
      do_reset();
      ready_mode = 1;
      rand_shifts(32);
      do_latch(3'd4);
      k = 0;
      while (!(wr_valid && wr_row == 4'd4 && wr_col == 5'd20) && k < 200) begin
         cyc(1);
         k++;
      end
      check("mid_reached", k < 200, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", wr_valid, 0);
      check("mid_rst_disp", disp_row, 7);
      exp_q.delete(); shifted.delete();
      m_disp = 3'd7; m_ovr = 1'b0; m_len = 1'b0;
      w0 = writes;
      cyc(3);
      rst_n = 1'b1;
      cyc(100);
      check("mid_no_writes", writes - w0, 0);
      check("mid_valid_low", wr_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 COLS, 32, columns shifted per line; ROW_BITS, 3, width of panel row address.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sclk_in  input  1  HUB75 shift clock, asynchronous to clk.
REQ-005 lat_in  input  1  HUB75 latch, active-high.
REQ-006 oe_n_in  input  1  HUB75 output enable, active-low.
REQ-007 a_in  input  ROW_BITS  HUB75 row address.
REQ-008 rgb1_in / rgb2_in  input  3 each  upper/lower half pixel bits {r,g,b}.
REQ-009 wr_valid  output  1  pixel write valid.
REQ-010 wr_ready  input  1  pixel sink ready.
REQ-011 wr_row  output  ROW_BITS+1  pixel row, 0..15.
REQ-012 wr_col  output  5  pixel column, 0..31.
REQ-013 wr_rgb  output  3  pixel colour.
REQ-014 disp_row  output  ROW_BITS  row address captured at last accepted latch.
REQ-015 lit  output  1  synchronized inverse of oe_n_in.
REQ-016 frame_done  output  1  one-cycle pulse at frame boundary.
REQ-017 overrun, len_err  output  1 each  sticky error flags.

Function
REQ-018 All HUB75 inputs SHALL pass through a 2-flop synchronizer; edges SHALL be detected on synchronized signals only.
REQ-019 On each synchronized sclk rising edge, {rgb1,rgb2} SHALL be shifted into a 32x6 shift register and shift count incremented, saturating at 63.
REQ-020 Column mapping: the bit shifted first SHALL be column 31, the last shifted column 0.
REQ-021 On synchronized lat rising edge with drain FSM IDLE: shift register copied to line buffer, a captured to disp_row, shift count cleared, FSM to UPPER.
REQ-022 Lat edge while FSM not IDLE: line dropped, overrun set, shift count cleared, disp_row unchanged.
REQ-023 Lat edge with shift count != COLS: len_err set, line still accepted (missing columns = 0, extras = last 32 shifted).
REQ-024 FSM states IDLE, UPPER, LOWER; UPPER emits cols 0..31 with wr_row = {0,disp_row}, rgb1 bits; LOWER same with wr_row = {1,disp_row}, rgb2 bits; LOWER col 31 accepted -> IDLE.
REQ-025 Valid/ready: wr_valid high in UPPER/LOWER; column advances only on wr_valid && wr_ready; outputs stable while stalled.
REQ-026 Shifting SHALL continue during drain (double-buffered); sclk and lat edges in same cycle: shift first, then latch includes that bit.
REQ-027 frame_done SHALL pulse one cycle after an accepted latch whose a equals 0 when previous accepted disp_row was 7.
REQ-028 Minimum drain time 64 cycles with wr_ready held high; first wr_valid 1 cycle after latch detection.

Reset
REQ-029 Reset: wr_valid 0, wr_row 0, wr_col 0, wr_rgb 0, disp_row 7, lit 0, frame_done 0, overrun 0, len_err 0, FSM IDLE, shift count 0, synchronizers cleared.
REQ-030 Reset mid-drain SHALL abort drain immediately; no partial write after release.
REQ-031 Sticky flags cleared only by reset.

Structure
REQ-032 Shared package hub75_pkg: COLS, ROW_BITS, rgb_t (3-bit packed struct r,g,b), drain state enum.
REQ-033 One sub-module hub75_sync (2-flop synchronizer + rising-edge detect), instantiated per control signal; data bits use plain synchronizer.

Verification
REQ-034 Shift 32 columns pattern col c = c[2:0] on rgb1, ~c[2:0] on rgb2, a=3, latch, wr_ready=1 -> 64 writes, rows 3 then 11, cols 0..31, correct colours, disp_row=3.
REQ-035 Rows 0..7 in order then row 0 -> frame_done exactly one pulse after second row-0 latch.
REQ-036 wr_ready toggled every other cycle -> 64 writes, no duplicates, outputs stable when stalled.
REQ-037 Second latch 10 cycles after first, wr_ready=0 -> overrun=1, only first line written, disp_row unchanged.
REQ-038 30 sclk pulses then latch -> len_err=1, cols 0..1 written as 0.
REQ-039 Assert rst at column 20 of UPPER -> wr_valid 0 asynchronously, disp_row 7, no writes after release.
